inst_stats_unit: RTL and testbench
==================================

INST_STATS_UNIT -- requirements
Module: inst_stats_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of every counter.
REQ-002 SHALL have parameter NREG, default 4, number of tracked destination registers.
REQ-003 SHALL have parameter REG_BASE, default 3, lowest tracked register index; window is REG_BASE..REG_BASE+NREG-1, and REG_BASE+NREG SHALL be <= 32.
REQ-004 SHALL use one clock and an asynchronous active-low reset; no other clock or reset inputs.
REQ-005 clk  input  1  clock; all state updates on posedge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 inst_valid  input  1  inst32 carries a retired instruction this cycle.
REQ-008 inst32  input  32  instruction word.
REQ-009 clear  input  1  synchronous zeroing of all counters and the decode stage.
REQ-010 rd_en  input  1  read request.
REQ-011 rd_sel  input  $clog2(NREG+3)  counter select: 0=R, 1=I, 2=J, 3+k=register REG_BASE+k.
REQ-012 rd_data  output  CNT_W  selected counter value.
REQ-013 rd_valid  output  1  rd_data is valid this cycle.

Function
REQ-014 Classification SHALL be: opcode inst32[31:26]==0 is R-type; opcode 2 or 3 is J-type; every other opcode is I-type.
REQ-015 Destination register SHALL be inst32[15:11] for R-type and inst32[20:16] for I-type; J-type has none.
REQ-016 Stage 1 SHALL register class, destination and a valid bit on the posedge where inst_valid=1.
REQ-017 Stage 2 SHALL, on the next posedge, increment exactly one class counter and, if the destination lies in the window, the matching register counter.
REQ-018 Counter latency SHALL be 2 posedges from acceptance; back-to-back inst_valid SHALL sustain one instruction per cycle with no stall.
REQ-019 A destination outside the window SHALL update only the class counter.
REQ-020 clear=1 SHALL zero all counters and the stage-1 valid bit on that posedge, overriding any same-cycle increment; an instruction presented with clear=1 SHALL be dropped.
REQ-021 Read SHALL be registered: rd_en=1 at posedge N gives rd_data and rd_valid=1 after posedge N, holding the counter value from before that edge's update.
REQ-022 rd_valid SHALL be 0 in any cycle following a posedge with rd_en=0; rd_data SHALL then hold its last value.
REQ-023 rd_sel >= NREG+3 SHALL return rd_data=0 with rd_valid=1.
REQ-024 Counter overflow behaviour SHALL be set by REQ-028.

Reset
REQ-025 rst_n=0 SHALL asynchronously zero all counters, the stage-1 valid bit, rd_data and rd_valid.
REQ-026 Reset asserted mid-stream SHALL discard any instruction in stage 1; counting SHALL resume from the first inst_valid after the first posedge with rst_n=1.

Configuration
REQ-027 Macro INST_STATS_SAT_EN SHALL select the counter overflow mode.
REQ-028 With INST_STATS_SAT_EN defined, counters SHALL saturate at 2^CNT_W-1; without it, counters SHALL wrap modulo 2^CNT_W.

Structure
REQ-029 Package inst_stats_pkg SHALL hold the opcode constants (R=6'h00, J=6'h02, JAL=6'h03) and a 2-bit instruction-class typedef (R, I, J).
REQ-030 Sub-module inst_classify SHALL perform the combinational decode of inst32 into class and destination register; inst_stats_unit instantiates it once.

Verification
REQ-031 Reset, then inst_valid with 32'h00851820 (R-type, rd=3) -> after 2 edges, rd_sel=0 reads 1 and rd_sel=3 reads 1.
REQ-032 Back-to-back 32'h20040005 (I, rt=4), 32'h08000010 (J), 32'h00003820 (R, rd=7, outside window) -> I=1, J=1, R=1, register 4 counter=1, and registers 3, 5, 6 counters stay 0.
REQ-033 CNT_W=8, 256 consecutive R-types -> R reads 255 with INST_STATS_SAT_EN defined, 0 without.
REQ-034 clear asserted on the same edge as a valid R-type, with another R-type in stage 1 -> all counters read 0 afterwards; the following R-type gives R=1.
REQ-035 rd_en with rd_sel=0 on the edge where the R counter goes 4->5 -> rd_data=4 and rd_valid=1; rd_sel=7 with NREG=4 -> rd_data=0.
REQ-036 rst_n pulsed low between clock edges while stage 1 holds a valid instruction -> all outputs are 0 immediately, and the held instruction is never counted.

Source files
------------

// File: rtl/inst_stats_pkg.sv
// Shared opcode constants and the instruction-class type for the instruction statistics unit.
package inst_stats_pkg;

   localparam logic [5:0] OP_R   = 6'h00;
   localparam logic [5:0] OP_J   = 6'h02;
   localparam logic [5:0] OP_JAL = 6'h03;

   // Encoding doubles as the counter index of each class counter.
   typedef enum logic [1:0] {
      CLS_R = 2'd0,
      CLS_I = 2'd1,
      CLS_J = 2'd2
   } inst_class_t;

endpackage

// File: rtl/inst_classify.sv
// Combinational decode of a 32-bit instruction word into class and destination register.
module inst_classify
   import inst_stats_pkg::*;
(
   input  logic [31:0]  inst32,
   output inst_class_t  cls,
   output logic [4:0]   rd,
   output logic         has_rd
);

   logic [5:0] op;
   logic       unused_bits;

   assign op          = inst32[31:26];
   assign unused_bits = &{1'b0, inst32[25:21], inst32[10:0]};

   always_comb begin
      cls    = CLS_I;
      rd     = inst32[20:16];
      has_rd = 1'b1;
      if (op == OP_R) begin
         cls = CLS_R;
         rd  = inst32[15:11];
      end else if (op == OP_J || op == OP_JAL) begin
         cls    = CLS_J;
         rd     = '0;
         has_rd = 1'b0;
      end
   end

endmodule

// File: rtl/inst_stats_unit.sv
// Two-stage retired-instruction statistics: class counters plus a window of destination-register counters.
// Define INST_STATS_SAT_EN for saturating counters; otherwise counters wrap.
module inst_stats_unit
   import inst_stats_pkg::*;
#(
   parameter int CNT_W    = 8,
   parameter int NREG     = 4,
   parameter int REG_BASE = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          inst_valid,
   input  logic [31:0]                   inst32,
   input  logic                          clear,
   input  logic                          rd_en,
   input  logic [$clog2(NREG+3)-1:0]     rd_sel,
   output logic [CNT_W-1:0]              rd_data,
   output logic                          rd_valid
);

   localparam int NCNT = NREG + 3;
   localparam int SW   = $clog2(NREG + 3);

   inst_class_t      dec_cls;
   logic [4:0]       dec_rd;
   logic             dec_has_rd;

   logic             s1_valid;
   inst_class_t      s1_cls;
   logic [4:0]       s1_rd;
   logic             s1_has_rd;

   int               rd_off;
   logic             in_win;
   logic [SW-1:0]    cls_idx;
   logic [SW-1:0]    reg_idx;
   logic             sel_in_range;

   // Index 0..2 = R/I/J class counters, 3+k = register REG_BASE+k.
   logic [CNT_W-1:0] cnt [NCNT];

   function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef INST_STATS_SAT_EN
      bump = (&v) ? v : v + CNT_W'(1);
`else
      bump = v + CNT_W'(1);
`endif
   endfunction

   inst_classify u_classify (
      .inst32 (inst32),
      .cls    (dec_cls),
      .rd     (dec_rd),
      .has_rd (dec_has_rd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_cls    <= CLS_R;
         s1_rd     <= '0;
         s1_has_rd <= 1'b0;
      end else begin
         s1_valid <= inst_valid & ~clear;
         if (inst_valid) begin
            s1_cls    <= dec_cls;
            s1_rd     <= dec_rd;
            s1_has_rd <= dec_has_rd;
         end
      end
   end

   always_comb begin
      rd_off  = int'(s1_rd) - REG_BASE;
      in_win  = s1_has_rd && (rd_off >= 0) && (rd_off < NREG);
      cls_idx = SW'(s1_cls);
      reg_idx = SW'(rd_off + 3);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NCNT; k++) cnt[k] <= '0;
      end else if (clear) begin
         for (int k = 0; k < NCNT; k++) cnt[k] <= '0;
      end else if (s1_valid) begin
         cnt[cls_idx] <= bump(cnt[cls_idx]);
         if (in_win) cnt[reg_idx] <= bump(cnt[reg_idx]);
      end
   end

   // Read port: rd_en sampled at a posedge yields rd_valid=1 for exactly the following
   // cycle with the pre-edge counter value; with rd_en=0, rd_valid drops and rd_data holds.
   assign sel_in_range = int'(rd_sel) < NCNT;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) rd_data <= sel_in_range ? cnt[rd_sel] : '0;
      end
   end

endmodule

// File: tb/tb_inst_stats_unit.sv
// Directed bench for inst_stats_unit: single-instruction vector table plus multi-cycle sequences.
module tb_inst_stats_unit;

   localparam int CNT_W = 8;
   localparam int NREG  = 4;
   localparam int SW    = $clog2(NREG + 3);

   logic             clk;
   logic             rst_n;
   logic             inst_valid;
   logic [31:0]      inst32;
   logic             clear;
   logic             rd_en;
   logic [SW-1:0]    rd_sel;
   logic [CNT_W-1:0] rd_data;
   logic             rd_valid;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [31:0] inst;
      logic [6:0]  hit;   // bit k set: counter k must read 1, else 0
   } vec_t;

   vec_t vecs[10];

   inst_stats_unit #(.CNT_W(CNT_W), .NREG(NREG), .REG_BASE(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .inst_valid (inst_valid),
      .inst32     (inst32),
      .clear      (clear),
      .rd_en      (rd_en),
      .rd_sel     (rd_sel),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] inst);
      inst_valid = 1'b1;
      inst32     = inst;
      tick();
      inst_valid = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic read_chk(input string name, input int sel, input logic [CNT_W-1:0] exp);
      rd_en  = 1'b1;
      rd_sel = SW'(sel);
      tick();
      rd_en  = 1'b0;
      check({name, " valid"}, 32'(rd_valid), 32'd1);
      check(name, 32'(rd_data), 32'(exp));
   endtask

   initial begin
      rst_n = 1'b0; inst_valid = 1'b0; inst32 = '0; clear = 1'b0; rd_en = 1'b0; rd_sel = '0;

      vecs[0] = '{32'h00851820, 7'b0001001};  // R, rd=3
      vecs[1] = '{32'h20040005, 7'b0010010};  // I, rt=4
      vecs[2] = '{32'h08000010, 7'b0000100};  // J
      vecs[3] = '{32'h00003820, 7'b0000001};  // R, rd=7 outside
      vecs[4] = '{32'h0C000000, 7'b0000100};  // JAL
      vecs[5] = '{32'h8C060000, 7'b1000010};  // I, rt=6 top of window
      vecs[6] = '{32'h00001020, 7'b0000001};  // R, rd=2 below window
      vecs[7] = '{32'h34050000, 7'b0100010};  // I, rt=5
      vecs[8] = '{32'hFC030000, 7'b0001010};  // I opcode 63, rt=3
      vecs[9] = '{32'h00041020, 7'b0000001};  // R, rt=4 but rd=2

      tick(); tick();
      check("reset rd_valid", 32'(rd_valid), 32'd0);
      check("reset rd_data", 32'(rd_data), 32'd0);
      rst_n = 1'b1;
      tick();

      // Latency: accepted at edge A, visible to a read sampled at edge A+2.
      issue(32'h00851820);
      read_chk("latency R pre-update", 0, 8'd0);
      read_chk("latency R", 0, 8'd1);
      read_chk("latency reg3", 3, 8'd1);

      for (int i = 0; i < 10; i++) begin
         do_clear();
         issue(vecs[i].inst);
         tick();
         for (int k = 0; k < 7; k++)
            read_chk($sformatf("vec%0d sel%0d", i, k), k, vecs[i].hit[k] ? 8'd1 : 8'd0);
      end

      // Back-to-back stream with no idle cycles.
      do_clear();
      issue(32'h20040005);
      issue(32'h08000010);
      issue(32'h00003820);
      tick();
      read_chk("b2b R", 0, 8'd1);
      read_chk("b2b I", 1, 8'd1);
      read_chk("b2b J", 2, 8'd1);
      read_chk("b2b reg3", 3, 8'd0);
      read_chk("b2b reg4", 4, 8'd1);
      read_chk("b2b reg5", 5, 8'd0);
      read_chk("b2b reg6", 6, 8'd0);

      // 256 R-types: saturate or wrap.
      do_clear();
      inst_valid = 1'b1;
      inst32     = 32'h00000020;
      for (int i = 0; i < 256; i++) tick();
      inst_valid = 1'b0;
      tick();
`ifdef INST_STATS_SAT_EN
      read_chk("overflow R", 0, 8'd255);
`else
      read_chk("overflow R", 0, 8'd0);
`endif

      // clear on the same edge as a valid R-type, with another R-type in stage 1.
      do_clear();
      issue(32'h00851820);
      issue(32'h00851820);
      inst_valid = 1'b1; inst32 = 32'h00851820; clear = 1'b1;
      tick();
      inst_valid = 1'b0; clear = 1'b0;
      tick();
      read_chk("clear R", 0, 8'd0);
      read_chk("clear reg3", 3, 8'd0);
      issue(32'h00851820);
      tick();
      read_chk("after clear R", 0, 8'd1);

      // Read on the edge where R goes 4->5 returns the old value.
      do_clear();
      for (int i = 0; i < 5; i++) issue(32'h00000020);
      read_chk("read during update", 0, 8'd4);
      read_chk("read after update", 0, 8'd5);
      tick();
      check("idle rd_valid", 32'(rd_valid), 32'd0);
      check("idle rd_data hold", 32'(rd_data), 32'd5);
      read_chk("sel out of range", 7, 8'd0);

      // Asynchronous reset between edges while stage 1 holds an instruction.
      do_clear();
      issue(32'h00000020);
      issue(32'h00000020);
      tick();
      rd_en = 1'b1; rd_sel = '0;
      issue(32'h00000020);
      rd_en = 1'b0;
      check("pre-reset rd_data", 32'(rd_data), 32'd2);
      #3 rst_n = 1'b0;
      #1;
      check("async rst rd_valid", 32'(rd_valid), 32'd0);
      check("async rst rd_data", 32'(rd_data), 32'd0);
      #1 rst_n = 1'b1;
      read_chk("post-reset R", 0, 8'd0);
      tick();
      read_chk("held inst dropped", 0, 8'd0);
      issue(32'h00000020);
      tick();
      read_chk("resume R", 0, 8'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
